fuzz_stim_gen: RTL and testbench

//  Synthesizable stimulus source for the fuzz harness; sits directly upstream of the DUT wrapper's in_flat.

---
 rtl/fuzz_lcg_pkg.sv | 26 ++
 rtl/fuzz_stim_gen_if.sv | 35 +++
 rtl/fuzz_lcg_core.sv | 37 +++
 rtl/fuzz_stim_gen.sv | 174 +++++++++++++++++
 tb/tb_fuzz_stim_gen.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fuzz_lcg_pkg.sv
// ---------------------------------------------------------------------------
// fuzz_lcg_pkg
// Shared definitions for the fuzz stimulus generator: the harness 32-bit LCG
// constants, the reset seed, the single-step LCG function and the generator
// FSM state type. The simulator-side generator uses the same constants so a
// seed replays identically on hardware and in simulation.
// ---------------------------------------------------------------------------
package fuzz_lcg_pkg;

    localparam logic [31:0] LCG_MULT     = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC      = 32'h3039;
    localparam logic [31:0] DEFAULT_SEED = 32'hEE0CAEB5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } stim_state_e;

    // One LCG step; the mod 2^32 wrap is the natural 32-bit truncation.
    function automatic logic [31:0] lcg_next(input logic [31:0] s);
        return s * LCG_MULT + LCG_INC;
    endfunction

endpackage

// File: rtl/fuzz_stim_gen_if.sv
// ---------------------------------------------------------------------------
// fuzz_stim_gen_if
// Vector delivery channel from the stimulus generator to its consumer.
//   vec_o        stimulus vector
//   vec_valid_o  vec_o holds a complete vector
//   vec_ready_i  consumer accepts vec_o
//   vec_idx_o    0-based index of the vector on vec_o
// Handshake: a vector transfers on a clock edge where vec_valid_o and
// vec_ready_i are both high. Once vec_valid_o is high, it and vec_o/vec_idx_o
// stay stable until that transfer (only abort or reset may withdraw it).
// vec_ready_i may change freely and may be high while vec_valid_o is low.
// ---------------------------------------------------------------------------
interface fuzz_stim_gen_if #(
    parameter int VEC_W = 271,
    parameter int CNT_W = 32
);
    logic [VEC_W-1:0] vec_o;
    logic             vec_valid_o;
    logic             vec_ready_i;
    logic [CNT_W-1:0] vec_idx_o;

    modport master (
        output vec_o,
        output vec_valid_o,
        output vec_idx_o,
        input  vec_ready_i
    );

    modport slave (
        input  vec_o,
        input  vec_valid_o,
        input  vec_idx_o,
        output vec_ready_i
    );
endinterface

// File: rtl/fuzz_lcg_core.sv
// ---------------------------------------------------------------------------
// fuzz_lcg_core
// 32-bit LCG state register.
//   clk, rst_n  clock / asynchronous active-low reset (state <= RESET_SEED)
//   load_i      load seed_i into the state (wins over step_i)
//   seed_i      seed value
//   step_i      advance the state by one LCG step
//   next_o      lcg_next(state): the value the state becomes on a step
// ---------------------------------------------------------------------------
module fuzz_lcg_core
    import fuzz_lcg_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'hEE0CAEB5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        step_i,
    output logic [31:0] next_o
);

    logic [31:0] state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_SEED;
        end else if (load_i) begin
            state_q <= seed_i;
        end else if (step_i) begin
            state_q <= lcg_next(state_q);
        end
    end

    assign next_o = lcg_next(state_q);

endmodule

// File: rtl/fuzz_stim_gen.sv
// ---------------------------------------------------------------------------
// fuzz_stim_gen
// Stimulus source for the fuzz harness. Builds VEC_W-bit vectors LSB-first
// from successive LCG outputs (one 32-bit chunk per cycle) and hands them to
// the consumer over a valid/ready channel.
//   clk, rst_n   clock / asynchronous active-low reset
//   start_i      begin a run (only looked at in IDLE)
//   abort_i      end the run now: back to IDLE, no done pulse
//   seed_i       LCG seed captured on start
//   num_vec_i    number of vectors in the run, captured on start
//   vec          vector channel (master side)
//   busy_o       run in progress (state != IDLE)
//   done_o       one-cycle pulse when a run completes
//   state_o      current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module fuzz_stim_gen
    import fuzz_lcg_pkg::*;
#(
    parameter int          VEC_W        = 271,
    parameter logic [31:0] DEFAULT_SEED = fuzz_lcg_pkg::DEFAULT_SEED,
    parameter int          CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [31:0]            seed_i,
    input  logic [CNT_W-1:0]       num_vec_i,
    fuzz_stim_gen_if.master        vec,
    output logic                   busy_o,
    output logic                   done_o,
    output stim_state_e            state_o
);

    localparam int NCHUNK   = (VEC_W + 31) / 32;
    // Width of the final, possibly partial, chunk (15 for VEC_W = 271).
    localparam int LAST_W   = VEC_W - 32 * (NCHUNK - 1);
    localparam int CHUNK_CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CHUNK_CW-1:0] LAST_CHUNK = CHUNK_CW'(NCHUNK - 1);

    stim_state_e          state_q, state_d;
    logic [CHUNK_CW-1:0]  chunk_ctr_q;
    logic [VEC_W-1:0]     vec_q;
    logic [CNT_W-1:0]     remaining_q;
    logic [CNT_W-1:0]     idx_q;

    logic                 lcg_load;
    logic                 lcg_step;
    logic                 capture;
    logic                 fill_en;
    logic                 accept;
    logic [31:0]          lcg_out;

    fuzz_lcg_core #(
        .RESET_SEED (DEFAULT_SEED)
    ) u_lcg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (lcg_load),
        .seed_i (seed_i),
        .step_i (lcg_step),
        .next_o (lcg_out)
    );

    // -------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lcg_load = 1'b0;
        lcg_step = 1'b0;
        capture  = 1'b0;
        fill_en  = 1'b0;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    lcg_load = 1'b1;
                    capture  = 1'b1;
                    state_d  = (num_vec_i == '0) ? FINISH : FILL;
                end
            end
            FILL: begin
                // The LCG output feeding this chunk is also the new state,
                // so the stream continues unbroken across vectors.
                lcg_step = 1'b1;
                fill_en  = 1'b1;
                if (chunk_ctr_q == LAST_CHUNK) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (vec.vec_ready_i) begin
                    accept  = 1'b1;
                    state_d = (remaining_q == CNT_W'(1)) ? FINISH : FILL;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides start and handshake; the LCG keeps its value.
        if (abort_i) begin
            state_d  = IDLE;
            lcg_load = 1'b0;
            lcg_step = 1'b0;
            capture  = 1'b0;
            fill_en  = 1'b0;
            accept   = 1'b0;
        end
    end

    // -------------------------------------------------------------------
    // Datapath: chunk counter, vector assembly, run counters
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunk_ctr_q <= '0;
            vec_q       <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
        end else begin
            if (capture) begin
                chunk_ctr_q <= '0;
                remaining_q <= num_vec_i;
                idx_q       <= '0;
            end

            if (fill_en) begin
                for (int k = 0; k < NCHUNK - 1; k++) begin
                    if (chunk_ctr_q == CHUNK_CW'(k)) begin
                        vec_q[32*k +: 32] <= lcg_out;
                    end
                end
                if (chunk_ctr_q == LAST_CHUNK) begin
                    vec_q[VEC_W-1 -: LAST_W] <= lcg_out[LAST_W-1:0];
                    chunk_ctr_q              <= '0;
                end else begin
                    chunk_ctr_q <= chunk_ctr_q + 1'b1;
                end
            end

            if (accept) begin
                remaining_q <= remaining_q - 1'b1;
                // Only advance when another vector follows, so the index
                // never wraps even for a run of 2^CNT_W-1 vectors.
                if (remaining_q != CNT_W'(1)) begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign vec.vec_o       = vec_q;
    assign vec.vec_valid_o = (state_q == PRESENT);
    assign vec.vec_idx_o   = idx_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == FINISH);
    assign state_o         = state_q;

endmodule

// File: tb/tb_fuzz_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_fuzz_stim_gen
// Directed bench for fuzz_stim_gen: reset values, known LCG chunks for
// seeds 0 and 1, start-to-valid latency, a 101-vector run with random ready
// against an independently generated LCG stream, empty run, abort in
// PRESENT, start ignored while busy, and reset in the middle of FILL.
// ---------------------------------------------------------------------------
module tb_fuzz_stim_gen;
    import fuzz_lcg_pkg::*;

    localparam int VEC_W  = 271;
    localparam int CNT_W  = 32;
    localparam int NCHUNK = 9;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [31:0]      seed_i = '0;
    logic [CNT_W-1:0] num_vec_i = '0;
    logic             busy_o;
    logic             done_o;
    stim_state_e      state_o;

    always #5 clk = ~clk;

    fuzz_stim_gen_if #(.VEC_W(VEC_W), .CNT_W(CNT_W)) vif ();

    fuzz_stim_gen #(
        .VEC_W        (VEC_W),
        .DEFAULT_SEED (32'hEE0CAEB5),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .seed_i    (seed_i),
        .num_vec_i (num_vec_i),
        .vec       (vif),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .state_o   (state_o)
    );

    // ---------------- scoreboard state ----------------
    int               total = 0;
    int               bad = 0;
    logic [VEC_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [VEC_W-1:0] obs,
                       input logic [VEC_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference generator ----------------
    function automatic logic [31:0] tb_lcg(input logic [31:0] s);
        return s * LCG_MULT + LCG_INC;
    endfunction

    task automatic model_vec(inout logic [31:0] s, output logic [VEC_W-1:0] v);
        logic [32*NCHUNK-1:0] t;
        t = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            s = tb_lcg(s);
            t[32*k +: 32] = s;
        end
        v = t[VEC_W-1:0];
    endtask

    // ---------------- driver tasks ----------------
    // All driving and sampling happens 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] seed, input logic [CNT_W-1:0] n);
        seed_i    = seed;
        num_vec_i = n;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
    endtask

    // n counts edges since start was sampled (the start edge is 1).
    task automatic wait_valid(output int n);
        n = 1;
        while (!vif.vec_valid_o && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vec"},   vif.vec_o, '0);
        chk({tag, "_valid"}, VEC_W'(vif.vec_valid_o), '0);
        chk({tag, "_idx"},   VEC_W'(vif.vec_idx_o), '0);
        chk({tag, "_busy"},  VEC_W'(busy_o), '0);
        chk({tag, "_done"},  VEC_W'(done_o), '0);
        chk({tag, "_state"}, VEC_W'(state_o), VEC_W'(IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0]      s;
        logic [VEC_W-1:0] v;
        logic [VEC_W-1:0] held;
        int               lat;
        int               got;
        int               done_cnt;
        int               cyc;
        logic             stalled;

        vif.vec_ready_i = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // seed=0, one vector, ready held high
        vif.vec_ready_i = 1'b1;
        start_run(32'h0, 1);
        chk("s0_busy", VEC_W'(busy_o), VEC_W'(1));
        wait_valid(lat);
        chk("s0_latency", VEC_W'(lat), VEC_W'(10));
        chk("s0_chunk0", VEC_W'(vif.vec_o[31:0]), VEC_W'(32'h00003039));
        chk("s0_chunk1", VEC_W'(vif.vec_o[63:32]), VEC_W'(32'hD3DC167E));
        s = 32'h0;
        model_vec(s, v);
        chk("s0_vec", vif.vec_o, v);
        chk("s0_idx", VEC_W'(vif.vec_idx_o), '0);
        tick();
        chk("s0_valid_after_hs", VEC_W'(vif.vec_valid_o), '0);
        chk("s0_done", VEC_W'(done_o), VEC_W'(1));
        tick();
        chk("s0_done_clear", VEC_W'(done_o), '0);
        chk("s0_idle", VEC_W'(busy_o), '0);

        // seed=1, one vector
        start_run(32'h1, 1);
        wait_valid(lat);
        chk("s1_latency", VEC_W'(lat), VEC_W'(10));
        chk("s1_chunk0", VEC_W'(vif.vec_o[31:0]), VEC_W'(32'h41C67EA6));
        s = 32'h1;
        model_vec(s, v);
        chk("s1_vec", vif.vec_o, v);
        tick();
        chk("s1_done", VEC_W'(done_o), VEC_W'(1));
        tick();

        // num_vec=0: no vector, done on the cycle after start
        start_run(32'h1234, 0);
        chk("n0_valid", VEC_W'(vif.vec_valid_o), '0);
        chk("n0_done", VEC_W'(done_o), VEC_W'(1));
        chk("n0_busy", VEC_W'(busy_o), VEC_W'(1));
        tick();
        chk("n0_done_clear", VEC_W'(done_o), '0);
        chk("n0_busy_clear", VEC_W'(busy_o), '0);
        chk("n0_valid2", VEC_W'(vif.vec_valid_o), '0);

        // DEFAULT_SEED, 101 vectors, random ready
        s = 32'hEE0CAEB5;
        for (int i = 0; i < 101; i++) begin
            model_vec(s, v);
            exp_q.push_back(v);
        end
        vif.vec_ready_i = 1'b0;
        start_run(32'hEE0CAEB5, 101);
        got = 0;
        done_cnt = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (cyc < 4000 && done_cnt == 0) begin
            vif.vec_ready_i = 1'($urandom_range(0, 1));
            if (vif.vec_valid_o) begin
                if (stalled) begin
                    chk("rr_stall_vec", vif.vec_o, held);
                end
                if (vif.vec_ready_i) begin
                    if (exp_q.size() > 0) begin
                        v = exp_q.pop_front();
                        chk("rr_vec", vif.vec_o, v);
                    end else begin
                        chk("rr_extra_vec", VEC_W'(1), '0 | VEC_W'(exp_q.size()));
                    end
                    chk("rr_idx", VEC_W'(vif.vec_idx_o), VEC_W'(got));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = vif.vec_o;
                end
            end
            if (done_o) begin
                done_cnt++;
            end
            tick();
            cyc++;
        end
        chk("rr_count", VEC_W'(got), VEC_W'(101));
        chk("rr_done_seen", VEC_W'(done_cnt), VEC_W'(1));
        chk("rr_queue_empty", VEC_W'(exp_q.size()), '0);
        chk("rr_done_one_cycle", VEC_W'(done_o), '0);
        chk("rr_idle", VEC_W'(busy_o), '0);
        tick();

        // Abort in PRESENT with ready high; start during FILL ignored
        vif.vec_ready_i = 1'b0;
        start_run(32'h5, 3);
        tick();
        seed_i    = 32'h99;
        num_vec_i = 0;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        wait_valid(lat);
        s = 32'h5;
        model_vec(s, v);
        chk("ign_start_vec", vif.vec_o, v);
        vif.vec_ready_i = 1'b1;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        vif.vec_ready_i = 1'b0;
        chk("ab_valid", VEC_W'(vif.vec_valid_o), '0);
        chk("ab_state", VEC_W'(state_o), VEC_W'(IDLE));
        chk("ab_done", VEC_W'(done_o), '0);
        chk("ab_idx", VEC_W'(vif.vec_idx_o), '0);
        tick();
        chk("ab_done2", VEC_W'(done_o), '0);

        // Reset in the middle of FILL, then replay the same seed
        start_run(32'h7, 2);
        tick();
        tick();
        tick();
        chk("mr_in_fill", VEC_W'(state_o), VEC_W'(FILL));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mr");
        tick();
        rst_n = 1'b1;
        tick();
        vif.vec_ready_i = 1'b1;
        start_run(32'h7, 1);
        wait_valid(lat);
        chk("mr_latency", VEC_W'(lat), VEC_W'(10));
        s = 32'h7;
        model_vec(s, v);
        chk("mr_vec", vif.vec_o, v);
        tick();
        chk("mr_done", VEC_W'(done_o), VEC_W'(1));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
